// File: rtl/demux5_1to2_buffered_pkg.sv
`default_nettype none
// ============================================================================
// Module      : demux5_1to2_buffered_pkg
// Description : Shared constants for the buffered 1-to-2 demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package demux5_1to2_buffered_pkg;

    localparam int unsigned WIDTH_DEF = 5;
    localparam int unsigned DEPTH_DEF = 2;
    localparam int unsigned CNT_W     = 2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage : demux5_1to2_buffered_pkg
`default_nettype wire

// File: rtl/demux5_1to2_buffered_fifo5x2.sv
`default_nettype none
// ============================================================================
// Module      : fifo5x2
// Description : Two-entry synchronous FIFO with push/pop/full/empty/count.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo5x2
    import demux5_1to2_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic [WIDTH-1:0] last_q,   last_d;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (count_q == CNT_W'(DEPTH));
    assign w_empty = (count_q == '0);
    assign w_push  = push_i & ~w_full;
    assign w_pop   = pop_i  & ~w_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        last_d   = last_q;
        if (w_push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (w_pop) begin
            rd_ptr_d = ~rd_ptr_q;
            last_d   = mem_q[rd_ptr_q];
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            last_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
            if (w_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    // An empty FIFO keeps presenting the word most recently popped.
    assign data_o  = w_empty ? last_q : mem_q[rd_ptr_q];
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = count_q;

endmodule : fifo5x2
`default_nettype wire

// File: rtl/demux5_1to2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : demux5_1to2_buffered
// Description : Routes each input word to one of two 2-entry output buffers.
// Revision    : 1.0 - initial release
// ============================================================================
module demux5_1to2_buffered
    import demux5_1to2_buffered_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] b_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic w_a_full, w_a_empty;
    logic w_b_full, w_b_empty;
    logic w_accept;
    logic w_a_push, w_b_push;
    logic w_a_pop,  w_b_pop;

    // Readiness looks only at the selected buffer's occupancy, never at pops.
    assign in_ready = ~reset & ((in_op == PORT_B) ? ~w_b_full : ~w_a_full);
    assign w_accept = in_valid & in_ready;
    assign w_a_push = w_accept & (in_op == PORT_A);
    assign w_b_push = w_accept & (in_op == PORT_B);

    assign a_valid  = ~w_a_empty;
    assign b_valid  = ~w_b_empty;
    assign w_a_pop  = a_valid & a_ready;
    assign w_b_pop  = b_valid & b_ready;

    fifo5x2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_a_push),
        .pop_i   (w_a_pop),
        .data_i  (in_data),
        .data_o  (a_data),
        .full_o  (w_a_full),
        .empty_o (w_a_empty),
        .count_o (a_count)
    );

    fifo5x2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_b_push),
        .pop_i   (w_b_pop),
        .data_i  (in_data),
        .data_o  (b_data),
        .full_o  (w_b_full),
        .empty_o (w_b_empty),
        .count_o (b_count)
    );

endmodule : demux5_1to2_buffered
`default_nettype wire

// File: tb/tb_demux5_1to2_buffered.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux5_1to2_buffered
// Description : Scoreboard bench for the buffered 1-to-2 demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux5_1to2_buffered;

    logic       clk;
    logic       reset;
    logic [4:0] in_data;
    logic       in_op;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [4:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [1:0] a_count;
    logic [1:0] b_count;

    int n_cmp;
    int n_err;

    logic [4:0] qa[$];
    logic [4:0] qb[$];

    demux5_1to2_buffered #(
        .WIDTH (5),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_op    (in_op),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock of stimulus: drive after the falling edge, check the settled
    // outputs against the reference queues, then advance the model at the
    // rising edge.
    task automatic cycle(input logic v, input logic op, input logic [4:0] d,
                         input logic ar, input logic br, input logic rst);
        logic exp_rdy;
        reset = rst; in_valid = v; in_op = op; in_data = d;
        a_ready = ar; b_ready = br;
        #1;
        exp_rdy = rst ? 1'b0 : (op ? (qb.size() < 2) : (qa.size() < 2));
        n_cmp++;
        if (in_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL in_ready: got %b want %b (t=%0t)", in_ready, exp_rdy, $time);
        end
        if (!rst) begin
            n_cmp++;
            if (a_valid !== (qa.size() != 0) || a_count !== 2'(qa.size())) begin
                n_err++;
                $display("FAIL a_state: got valid=%b count=%0d want count=%0d (t=%0t)",
                         a_valid, a_count, qa.size(), $time);
            end
            n_cmp++;
            if (b_valid !== (qb.size() != 0) || b_count !== 2'(qb.size())) begin
                n_err++;
                $display("FAIL b_state: got valid=%b count=%0d want count=%0d (t=%0t)",
                         b_valid, b_count, qb.size(), $time);
            end
            if (qa.size() != 0) begin
                n_cmp++;
                if (a_data !== qa[0]) begin
                    n_err++;
                    $display("FAIL a_head: got %b want %b (t=%0t)", a_data, qa[0], $time);
                end
            end
            if (qb.size() != 0) begin
                n_cmp++;
                if (b_data !== qb[0]) begin
                    n_err++;
                    $display("FAIL b_head: got %b want %b (t=%0t)", b_data, qb[0], $time);
                end
            end
        end
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (ar && qa.size() != 0) void'(qa.pop_front());
            if (br && qb.size() != 0) void'(qb.pop_front());
            if (v && exp_rdy) begin
                if (op) qb.push_back(d);
                else    qa.push_back(d);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1);
        reset = 1'b0; in_valid = 1'b0; #1;
        n_cmp++;
        if (a_count !== 2'd0 || b_count !== 2'd0 || a_valid !== 1'b0 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got ac=%0d bc=%0d av=%b bv=%b want 0", a_count, b_count, a_valid, b_valid);
        end
        n_cmp++;
        if (a_data !== 5'd0 || b_data !== 5'd0) begin
            n_err++;
            $display("FAIL reset_data: got a=%b b=%b want 00000", a_data, b_data);
        end
    endtask

    task automatic test_single_push();
        cycle(1'b1, 1'b0, 5'b10011, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; #1;
        n_cmp++;
        if (a_valid !== 1'b1 || a_data !== 5'b10011 || a_count !== 2'd1 || b_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_push: got av=%b ad=%b ac=%0d bv=%b want 1 10011 1 0",
                     a_valid, a_data, a_count, b_valid);
        end
    endtask

    task automatic test_fill_b();
        cycle(1'b1, 1'b1, 5'b11111, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'b10011, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; in_op = 1'b1; #1;
        n_cmp++;
        if (b_count !== 2'd2 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fill_b_op1: got bc=%0d rdy=%b want 2 0", b_count, in_ready);
        end
        in_op = 1'b0; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL fill_b_op0: got rdy=%b want 1", in_ready);
        end
    endtask

    task automatic test_full_refuse();
        cycle(1'b1, 1'b1, 5'b00001, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0; #1;
        n_cmp++;
        if (b_count !== 2'd1 || b_data !== 5'b10011) begin
            n_err++;
            $display("FAIL full_refuse: got bc=%0d bd=%b want 1 10011", b_count, b_data);
        end
    endtask

    task automatic test_push_pop_same();
        cycle(1'b1, 1'b0, 5'b11111, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b0; #1;
        n_cmp++;
        if (a_count !== 2'd1 || a_data !== 5'b11111) begin
            n_err++;
            $display("FAIL push_pop_same: got ac=%0d ad=%b want 1 11111", a_count, a_data);
        end
    endtask

    task automatic test_reset_mid();
        cycle(1'b1, 1'b0, 5'b00110, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 5'b01010, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b0; #1;
        n_cmp++;
        if (a_count !== 2'd2 || b_count !== 2'd2) begin
            n_err++;
            $display("FAIL fill_both: got ac=%0d bc=%0d want 2 2", a_count, b_count);
        end
        cycle(1'b1, 1'b0, 5'b00111, 1'b1, 1'b1, 1'b1);
        reset = 1'b0; in_valid = 1'b0; in_op = 1'b0; #1;
        n_cmp++;
        if (a_count !== 2'd0 || b_count !== 2'd0 || a_valid !== 1'b0 || b_valid !== 1'b0 ||
            a_data !== 5'd0 || b_data !== 5'd0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid: got ac=%0d bc=%0d av=%b bv=%b ad=%b bd=%b rdy=%b want zeros and rdy=1",
                     a_count, b_count, a_valid, b_valid, a_data, b_data, in_ready);
        end
        cycle(1'b1, 1'b1, 5'b10101, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 1000; i++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
        end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        reset = 1'b1; in_valid = 1'b0; in_op = 1'b0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_push();
        test_fill_b();
        test_full_refuse();
        test_push_pop_same();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_demux5_1to2_buffered
`default_nettype wire

// File: doc/demux5_1to2_buffered.md
DEMUX5_1TO2_BUFFERED -- requirements
Module: demux5_1to2_buffered

Interface
REQ-001 Parameter WIDTH, default 5, data word width in bits.
REQ-002 Parameter DEPTH, default 2, entries per output buffer; fixed at 2 in this release.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  word to route.
REQ-006 in_op  input  1  route select: 0 routes to port a, 1 routes to port b.
REQ-007 in_valid  input  1  in_data/in_op valid this cycle.
REQ-008 in_ready  output  1  block accepts the word this cycle.
REQ-009 a_data  output  WIDTH  head word of port-a buffer.
REQ-010 a_valid  output  1  port-a buffer non-empty.
REQ-011 a_ready  input  1  port-a consumer takes head this cycle.
REQ-012 b_data  output  WIDTH  head word of port-b buffer.
REQ-013 b_valid  output  1  port-b buffer non-empty.
REQ-014 b_ready  input  1  port-b consumer takes head this cycle.
REQ-015 a_count  output  2  port-a occupancy, 0..2.
REQ-016 b_count  output  2  port-b occupancy, 0..2.

Function
REQ-017 Accept = in_valid & in_ready at a rising edge; the word is written to the tail of the buffer selected by in_op sampled at that edge.
REQ-018 in_ready = NOT full(selected buffer), combinational from in_op and registered count only; no dependence on a_ready/b_ready.
REQ-019 Full buffer refuses writes even when its consumer pops the same cycle.
REQ-020 Pop = x_valid & x_ready at a rising edge; head advances, count decrements.
REQ-021 Latency: word accepted at edge N into an empty buffer appears on x_data with x_valid=1 after edge N (one cycle).
REQ-022 Per-port FIFO order preserved; no ordering relation between ports.
REQ-023 Simultaneous push and pop on same buffer with count=1: count stays 1, new word becomes head after popped word leaves.
REQ-024 Push to one port and pop from the other in same cycle are independent.
REQ-025 Pop on empty buffer (x_ready with x_valid=0): no state change, count stays 0.
REQ-026 x_data when x_valid=0 holds last head value; consumers must ignore it.
REQ-027 Read/write pointers are 1 bit each and wrap from 1 to 0; count never exceeds 2 nor underflows.
REQ-028 in_data is not altered; output word bits equal accepted input bits exactly.

Reset
REQ-029 reset high at an edge: a_count=b_count=0, a_valid=b_valid=0, a_data=b_data=0, pointers 0.
REQ-030 in_ready SHALL be 0 while reset is high; pushes and pops in a reset cycle are ignored.
REQ-031 Reset mid-operation discards all buffered words; first accept after reset release is treated as into empty buffers.

Structure
REQ-032 Shared package holds WIDTH default (5), DEPTH (2), count width (2) and the PORT_A=0/PORT_B=1 select constants.
REQ-033 One sub-module fifo5x2 (2-entry synchronous FIFO with push/pop/full/empty/count) instantiated twice, once per port; top holds only routing and ready logic.

Verification
REQ-034 Reset, then in_data=10011, in_op=0, in_valid=1 one cycle, a_ready=0 -> next cycle a_valid=1, a_data=10011, a_count=1, b_valid=0.
REQ-035 Push 11111 op=1 then 10011 op=1, b_ready=0 -> b_count=2, in_ready=0 with in_op=1, in_ready=1 with in_op=0.
REQ-036 Port b full, push 00001 op=1 with b_ready=1 same cycle -> push refused, b_count=1, b_data=10011 next cycle.
REQ-037 a_count=1 holding 10011, push 11111 op=0 and a_ready=1 same cycle -> a_count=1, a_data=11111.
REQ-038 Fill both ports (a_count=2, b_count=2), assert reset one cycle -> all counts 0, valids 0, data 0, in_ready=0 during reset, 1 after.
REQ-039 Random push/pop 1000 cycles against reference queue model -> per-port order matches, counts never exceed 2.
